// File: rtl/rtc_set_controller_pkg.sv
// Shared types and digit limits for the RTC time-set controller.
// Edit-field maxima are kept as BCD digit pairs so they compare directly.
package rtc_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    localparam logic [3:0] HR_MAX_M  = 4'd2;
    localparam logic [3:0] HR_MAX_L  = 4'd3;
    localparam logic [3:0] MIN_MAX_M = 4'd5;
    localparam logic [3:0] MIN_MAX_L = 4'd9;

endpackage

// File: rtl/rtc_set_controller_if.sv
// Button / current-time / parallel-load bus between the set controller and the RTC.
// disp_blank exists only when RTC_SET_BLINK_EN is defined.
interface rtc_set_controller_if;

    logic       btn_mode;
    logic       btn_inc;
    logic [3:0] cur_hr_m;
    logic [3:0] cur_hr_l;
    logic [3:0] cur_min_m;
    logic [3:0] cur_min_l;
    logic       run_en;
    logic       load_stb;
    logic [3:0] ld_hr_m;
    logic [3:0] ld_hr_l;
    logic [3:0] ld_min_m;
    logic [3:0] ld_min_l;
    logic [3:0] ld_sec_m;
    logic [3:0] ld_sec_l;
    logic [1:0] mode_state;
`ifdef RTC_SET_BLINK_EN
    logic [1:0] disp_blank;

    modport master (
        input  btn_mode, btn_inc, cur_hr_m, cur_hr_l, cur_min_m, cur_min_l,
        output run_en, load_stb, ld_hr_m, ld_hr_l, ld_min_m, ld_min_l,
               ld_sec_m, ld_sec_l, mode_state, disp_blank
    );

    modport slave (
        output btn_mode, btn_inc, cur_hr_m, cur_hr_l, cur_min_m, cur_min_l,
        input  run_en, load_stb, ld_hr_m, ld_hr_l, ld_min_m, ld_min_l,
               ld_sec_m, ld_sec_l, mode_state, disp_blank
    );
`else
    modport master (
        input  btn_mode, btn_inc, cur_hr_m, cur_hr_l, cur_min_m, cur_min_l,
        output run_en, load_stb, ld_hr_m, ld_hr_l, ld_min_m, ld_min_l,
               ld_sec_m, ld_sec_l, mode_state
    );

    modport slave (
        output btn_mode, btn_inc, cur_hr_m, cur_hr_l, cur_min_m, cur_min_l,
        input  run_en, load_stb, ld_hr_m, ld_hr_l, ld_min_m, ld_min_l,
               ld_sec_m, ld_sec_l, mode_state
    );
`endif

endinterface

// File: rtl/rtc_set_controller_bcd2_wrap_inc.sv
// Two-digit BCD increment that wraps to 00 after the supplied maximum pair.
module bcd2_wrap_inc (
    input  logic [3:0] val_m,
    input  logic [3:0] val_l,
    input  logic [3:0] max_m,
    input  logic [3:0] max_l,
    output logic [3:0] nxt_m,
    output logic [3:0] nxt_l
);

    // BCD pairs order the same as their 8-bit concatenation, so an
    // out-of-range captured value also falls back to 00.
    always_comb begin
        nxt_m = val_m;
        nxt_l = val_l;
        if ({val_m, val_l} >= {max_m, max_l}) begin
            nxt_m = 4'd0;
            nxt_l = 4'd0;
        end else if (val_l >= 4'd9) begin
            nxt_m = val_m + 4'd1;
            nxt_l = 4'd0;
        end else begin
            nxt_l = val_l + 4'd1;
        end
    end

endmodule

// File: rtl/rtc_set_controller.sv
// Button-driven HH:MM edit sequencer for the RTC chain with a one-cycle commit strobe.
// Optional edit-digit blink output enabled by defining RTC_SET_BLINK_EN.
module rtc_set_controller
    import rtc_pkg::*;
#(
    parameter int TIMEOUT_CYC = 30
`ifdef RTC_SET_BLINK_EN
   ,parameter int BLINK_CYC   = 1
`endif
) (
    input  logic clk,
    input  logic reset,
    rtc_set_controller_if.master bus
);

    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_t           state;
    logic [3:0]       edit_hr_m, edit_hr_l, edit_min_m, edit_min_l;
    logic [3:0]       nxt_hr_m, nxt_hr_l, nxt_min_m, nxt_min_l;
    logic [TMO_W-1:0] tmo_cnt;
    logic             editing;
    logic             timeout_hit;

    bcd2_wrap_inc u_hr_inc (
        .val_m(edit_hr_m), .val_l(edit_hr_l),
        .max_m(HR_MAX_M),  .max_l(HR_MAX_L),
        .nxt_m(nxt_hr_m),  .nxt_l(nxt_hr_l)
    );

    bcd2_wrap_inc u_min_inc (
        .val_m(edit_min_m), .val_l(edit_min_l),
        .max_m(MIN_MAX_M),  .max_l(MIN_MAX_L),
        .nxt_m(nxt_min_m),  .nxt_l(nxt_min_l)
    );

    assign editing     = (state == SET_HR) || (state == SET_MIN);
    assign timeout_hit = (TIMEOUT_CYC != 0) && editing && !bus.btn_mode && !bus.btn_inc &&
                         (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    assign bus.mode_state = state;
    assign bus.ld_sec_m   = 4'd0;
    assign bus.ld_sec_l   = 4'd0;

    // Mode is checked before inc in each edit state, so a simultaneous inc is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            bus.run_en   <= 1'b1;
            bus.load_stb <= 1'b0;
            bus.ld_hr_m  <= 4'd0;
            bus.ld_hr_l  <= 4'd0;
            bus.ld_min_m <= 4'd0;
            bus.ld_min_l <= 4'd0;
            edit_hr_m    <= 4'd0;
            edit_hr_l    <= 4'd0;
            edit_min_m   <= 4'd0;
            edit_min_l   <= 4'd0;
            tmo_cnt      <= '0;
        end else begin
            bus.load_stb <= 1'b0;
            unique case (state)
                RUN: begin
                    bus.run_en <= 1'b1;
                    if (bus.btn_mode) begin
                        edit_hr_m  <= bus.cur_hr_m;
                        edit_hr_l  <= bus.cur_hr_l;
                        edit_min_m <= bus.cur_min_m;
                        edit_min_l <= bus.cur_min_l;
                        tmo_cnt    <= '0;
                        bus.run_en <= 1'b0;
                        state      <= SET_HR;
                    end
                end
                SET_HR: begin
                    if (bus.btn_mode) begin
                        tmo_cnt <= '0;
                        state   <= SET_MIN;
                    end else if (bus.btn_inc) begin
                        edit_hr_m <= nxt_hr_m;
                        edit_hr_l <= nxt_hr_l;
                        tmo_cnt   <= '0;
                    end else if (timeout_hit) begin
                        tmo_cnt    <= '0;
                        bus.run_en <= 1'b1;
                        state      <= RUN;
                    end else if (TIMEOUT_CYC != 0) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                SET_MIN: begin
                    if (bus.btn_mode) begin
                        tmo_cnt      <= '0;
                        bus.load_stb <= 1'b1;
                        bus.ld_hr_m  <= edit_hr_m;
                        bus.ld_hr_l  <= edit_hr_l;
                        bus.ld_min_m <= edit_min_m;
                        bus.ld_min_l <= edit_min_l;
                        state        <= COMMIT;
                    end else if (bus.btn_inc) begin
                        edit_min_m <= nxt_min_m;
                        edit_min_l <= nxt_min_l;
                        tmo_cnt    <= '0;
                    end else if (timeout_hit) begin
                        tmo_cnt    <= '0;
                        bus.run_en <= 1'b1;
                        state      <= RUN;
                    end else if (TIMEOUT_CYC != 0) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    bus.run_en <= 1'b1;
                    state      <= RUN;
                end
            endcase
        end
    end

`ifdef RTC_SET_BLINK_EN
    localparam int BLK_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

    logic [BLK_W-1:0] blink_cnt;

    // Phase restarts on any state change or increment; only the field being edited blinks.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.disp_blank <= 2'b00;
            blink_cnt      <= '0;
        end else if (!editing || bus.btn_mode || timeout_hit || bus.btn_inc) begin
            bus.disp_blank <= 2'b00;
            blink_cnt      <= '0;
        end else if (blink_cnt == BLK_W'(BLINK_CYC - 1)) begin
            blink_cnt <= '0;
            if (state == SET_HR) begin
                bus.disp_blank <= {~bus.disp_blank[1], 1'b0};
            end else begin
                bus.disp_blank <= {1'b0, ~bus.disp_blank[0]};
            end
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`endif

endmodule
